// File: rtl/btn_debounce_pair_if.sv
// btn_debounce_pair_if
//   Bundles the raw button lines and the conditioned outputs of the
//   two-channel debouncer.
//   slave  : debouncer side (raw lines in, levels and pulses out)
//   master : consumer side  (drives raw lines, observes levels and pulses)
//   Signals:
//     btn_a_raw, btn_b_raw : raw asynchronous, bouncy inputs
//     a, b                 : debounced levels
//     a_rise, a_fall       : one-cycle edge pulses of a
//     b_rise, b_fall       : one-cycle edge pulses of b
interface btn_debounce_pair_if;
  logic btn_a_raw;
  logic btn_b_raw;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;

  modport slave (
    input  btn_a_raw, btn_b_raw,
    output a, b, a_rise, a_fall, b_rise, b_fall
  );

  modport master (
    output btn_a_raw, btn_b_raw,
    input  a, b, a_rise, a_fall, b_rise, b_fall
  );
endinterface

// File: rtl/btn_debounce_pair.sv
// btn_debounce_pair
//   Two independent input conditioners feeding the a/b inputs of a 2-input
//   OR gate. Each channel synchronises its raw line through two flops, then
//   only accepts a new level once it has persisted for DEBOUNCE_CYCLES
//   consecutive clocks. A one-cycle rise/fall pulse accompanies every
//   accepted change.
//   Ports:
//     clk   : system clock, all state on rising edge
//     rst_n : asynchronous active-low reset, clears every flop
//     bus   : slave modport of btn_debounce_pair_if (raw in, a/b + pulses out)
module btn_debounce_pair #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  btn_debounce_pair_if.slave         bus
);

  typedef enum logic {STABLE_LO = 1'b0, STABLE_HI = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0]       raw_vec;
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       rise_q, rise_d;
  logic [1:0]       fall_q, fall_d;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  assign raw_vec = {bus.btn_b_raw, bus.btn_a_raw};

  always_comb begin
    s1_d   = raw_vec;
    s2_d   = s1_q;
    rise_d = 2'b00;
    fall_d = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      if (s2_q[ch] == logic'(state_q[ch])) begin
        // Input agrees with the accepted level: any pending count is a bounce.
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        // Level has persisted long enough: accept it and flag the edge.
        cnt_d[ch]   = '0;
        state_d[ch] = (state_q[ch] == STABLE_HI) ? STABLE_LO : STABLE_HI;
        rise_d[ch]  = (state_q[ch] == STABLE_LO);
        fall_d[ch]  = (state_q[ch] == STABLE_HI);
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 2'b00;
      s2_q   <= 2'b00;
      rise_q <= 2'b00;
      fall_q <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= STABLE_LO;
        cnt_q[ch]   <= '0;
      end
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
    end
  end

  assign bus.a      = (state_q[0] == STABLE_HI);
  assign bus.b      = (state_q[1] == STABLE_HI);
  assign bus.a_rise = rise_q[0];
  assign bus.a_fall = fall_q[0];
  assign bus.b_rise = rise_q[1];
  assign bus.b_fall = fall_q[1];

endmodule
